// File: rtl/ascii_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ascii_pkg : shared byte constants and compactor state encoding   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package ascii_pkg;

  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_EOT = 8'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } compactor_state_t;

endpackage
`default_nettype wire

// File: rtl/ascii_compactor_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ascii_compactor_if : byte-in / byte-out handshake bundle          |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
interface ascii_compactor_if;

  logic       in_valid;
  logic [7:0] ascii_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] ascii_out;

  modport master (
    output in_valid,
    output ascii_in,
    output out_ready,
    input  out_valid,
    input  ascii_out
  );

  modport slave (
    input  in_valid,
    input  ascii_in,
    input  out_ready,
    output out_valid,
    output ascii_out
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_fifo : first-word-fall-through FIFO, wrap-bit pointers       |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] din,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full
);

  localparam int c_aw = $clog2(DEPTH);

  logic [c_aw:0]      r_wptr;
  logic [c_aw:0]      r_rptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_do_push;
  logic               w_do_pop;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                 (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);

  assign w_do_pop  = pop && !empty;
  // A full FIFO still takes a push when a pop frees a slot on the same edge.
  assign w_do_push = push && (!full || w_do_pop);

  assign dout = r_mem[r_rptr[c_aw-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (c_aw+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (c_aw+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[c_aw-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/ascii_compactor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ascii_compactor : drops NUL bytes, buffers the rest, EOT framing  |
// | optional statistics: ASCII_COMPACTOR_STATS_EN    rev 1.0          |
// +------------------------------------------------------------------+
module ascii_compactor
  import ascii_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  ascii_compactor_if.slave  bus,
  output logic              busy,
  output logic              eot_done,
`ifdef ASCII_COMPACTOR_STATS_EN
  output logic [15:0]       drop_count,
  output logic [15:0]       char_count,
`endif
  output logic              overflow
);

  compactor_state_t r_state;
  logic             r_busy;
  logic             r_eot_done;
  logic             r_overflow;

  logic             w_empty;
  logic             w_full;
  logic [7:0]       w_dout;
  logic             w_window;
  logic             w_nonnul;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (bus.ascii_in),
    .pop   (w_pop),
    .dout  (w_dout),
    .empty (w_empty),
    .full  (w_full)
  );

  assign w_window = (r_state == IDLE) || (r_state == STREAM);
  assign w_nonnul = bus.in_valid && (bus.ascii_in != ASCII_NUL);
  assign w_pop    = !w_empty && bus.out_ready;
  assign w_push   = w_window && w_nonnul && (!w_full || w_pop);
  assign w_drop   = w_window && w_nonnul && w_full && !w_pop;

  assign bus.out_valid = !w_empty;
  assign bus.ascii_out = w_empty ? ASCII_NUL : w_dout;
  assign busy          = r_busy;
  assign eot_done      = r_eot_done;
  assign overflow      = r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_eot_done <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_eot_done <= 1'b0;
      if (w_drop) r_overflow <= 1'b1;
      case (r_state)
        IDLE, STREAM: begin
          // A dropped EOT never reaches w_push, so it cannot start a drain.
          if (w_push) begin
            r_busy  <= 1'b1;
            r_state <= (bus.ascii_in == ASCII_EOT) ? DRAIN : STREAM;
          end
        end
        DRAIN: begin
          if (w_pop && (w_dout == ASCII_EOT)) begin
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_eot_done <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ASCII_COMPACTOR_STATS_EN
  logic [15:0] r_drop_count;
  logic [15:0] r_char_count;

  assign drop_count = r_drop_count;
  assign char_count = r_char_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_count <= '0;
      r_char_count <= '0;
    end else if (r_state == DONE) begin
      r_drop_count <= '0;
      r_char_count <= '0;
    end else begin
      if (w_window && bus.in_valid && (bus.ascii_in == ASCII_NUL) &&
          (r_drop_count != 16'hFFFF))
        r_drop_count <= r_drop_count + 16'd1;
      if (w_push && (r_char_count != 16'hFFFF))
        r_char_count <= r_char_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ascii_compactor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ascii_compactor : scoreboard bench with byte-stream model      |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_ascii_compactor;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, eot_done, overflow;
`ifdef ASCII_COMPACTOR_STATS_EN
  logic [15:0] drop_count, char_count;
`endif

  ascii_compactor_if bus ();

  ascii_compactor #(.DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .eot_done   (eot_done),
`ifdef ASCII_COMPACTOR_STATS_EN
    .drop_count (drop_count),
    .char_count (char_count),
`endif
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Bytes the consumer is owed, in order.
  logic [7:0] expq [$];

  // Model of the block after the upcoming clock edge.
  int         m_count;
  bit         m_stream, m_drain, m_done, m_ovf;
  int         m_drop, m_char;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_count = 0; m_stream = 0; m_drain = 0; m_done = 0; m_ovf = 0;
    m_drop = 0; m_char = 0;
    expq.delete();
  endfunction

  function automatic void model_step(bit v, logic [7:0] b, bit rdy);
    bit pop;
    bit cur_drain, cur_done;
    pop = (m_count > 0) && rdy;
    cur_drain = m_drain;
    cur_done  = m_done;
    m_done = 0;
    if (cur_done) begin
      m_stream = 0;
      m_drop = 0;
      m_char = 0;
    end else if (cur_drain) begin
      if (pop && m_count == 1) begin
        m_drain = 0;
        m_done  = 1;
      end
    end else if (v) begin
      if (b == 8'h00) begin
        if (m_drop < 16'hFFFF) m_drop++;
      end else if (m_count < D || pop) begin
        expq.push_back(b);
        m_count++;
        if (m_char < 16'hFFFF) m_char++;
        if (b == 8'h04) begin m_drain = 1; m_stream = 0; end
        else m_stream = 1;
      end else begin
        m_ovf = 1;
      end
    end
    if (pop) m_count--;
  endfunction

  function automatic void check_state();
    chk("out_valid", 32'(bus.out_valid), 32'(m_count > 0));
    chk("busy", 32'(busy), 32'(m_stream || m_drain));
    chk("eot_done", 32'(eot_done), 32'(m_done));
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef ASCII_COMPACTOR_STATS_EN
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    chk("char_count", 32'(char_count), 32'(m_char));
`endif
  endfunction

  task automatic step(bit v, logic [7:0] b, bit rdy);
    @(posedge clk); #1;
    check_state();
    bus.in_valid  = v;
    bus.ascii_in  = b;
    bus.out_ready = rdy;
    model_step(v, b, rdy);
  endtask

  task automatic async_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ascii_out", 32'(bus.ascii_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_eot_done", 32'(eot_done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    bus.in_valid = 1'b0; bus.ascii_in = 8'h00; bus.out_ready = 1'b0;
    model_reset();
    @(posedge clk); #3;
    rst = 1'b0;
  endtask

  // Monitor: a transfer happens on the coming edge whenever valid && ready.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_byte: got %0h want none at %0t", bus.ascii_out, $time);
        end else begin
          chk("data", 32'(bus.ascii_out), 32'(expq.pop_front()));
        end
      end else if (!bus.out_valid) begin
        chk("idle_ascii_out", 32'(bus.ascii_out), 32'd0);
      end
    end
  end

  logic [7:0] msg1 [12] = '{8'h48, 8'h00, 8'h6C, 8'h6C, 8'h00, 8'h20,
                            8'h57, 8'h00, 8'h72, 8'h6C, 8'h64, 8'h21};
  logic [7:0] msg3 [5]  = '{8'h41, 8'h42, 8'h04, 8'h43, 8'h44};

  initial begin
    bus.in_valid = 1'b0; bus.ascii_in = 8'h00; bus.out_ready = 1'b0;
    model_reset();
    #2 rst = 1'b1;
    #1;
    chk("init_out_valid", 32'(bus.out_valid), 32'd0);
    chk("init_ascii_out", 32'(bus.ascii_out), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #3 rst = 1'b0;

    // Vowel-stripped message, consumer always ready.
    foreach (msg1[i]) step(1, msg1[i], 1);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1);
`ifdef ASCII_COMPACTOR_STATS_EN
    chk("msg1_drop_count", 32'(drop_count), 32'd3);
    chk("msg1_char_count", 32'(char_count), 32'd9);
`endif

    // Overflow: six bytes into a stalled FIFO of four.
    for (int i = 0; i < 6; i++) step(1, 8'($urandom_range(8'h7E, 8'h20)), 0);
    step(0, 8'h00, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 1);

    async_reset();

    // EOT framing with a toggling consumer.
    foreach (msg3[i]) step(1, msg3[i], i[0]);
    for (int i = 0; i < 10; i++) step(0, 8'h00, i[0]);
    chk("eot_idle_busy", 32'(busy), 32'd0);

    // Full FIFO: push and pop together on the same edge.
    for (int i = 0; i < D; i++) step(1, 8'h30 + 8'(i), 0);
    step(1, 8'h39, 1);
    step(0, 8'h00, 0);
    chk("full_pushpop_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < D + 2; i++) step(0, 8'h00, 1);

    // Reset with three bytes buffered, then a fresh byte.
    for (int i = 0; i < 3; i++) step(1, 8'h61 + 8'(i), 0);
    async_reset();
    step(1, 8'h58, 1);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [7:0] b;
      r = int'($urandom_range(99, 0));
      if (r < 25) b = 8'h00;
      else if (r < 30) b = 8'h04;
      else b = 8'($urandom_range(8'h7E, 8'h20));
      step(bit'($urandom_range(1, 0)), b, ($urandom_range(3, 0) != 0));
    end
    for (int i = 0; i < 3 * D + 4; i++) step(0, 8'h00, 1);
    chk("final_queue_empty", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ascii_compactor.md
ASCII_COMPACTOR -- requirements
Module: ascii_compactor

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, 2..256.
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  ascii_in carries a byte this cycle.
REQ-005 ascii_in  input  8  byte from the vowel-removal stage; 8'h00 means "ignore".
REQ-006 out_valid  output  1  ascii_out holds a byte for the consumer.
REQ-007 out_ready  input  1  consumer accepts ascii_out this cycle.
REQ-008 ascii_out  output  8  compacted byte stream.
REQ-009 busy  output  1  high in states STREAM and DRAIN.
REQ-010 eot_done  output  1  one-cycle pulse when a message terminated by EOT has fully drained.
REQ-011 overflow  output  1  sticky flag: a non-NUL byte was lost.

Function
REQ-012 Byte transfer out SHALL occur on a rising edge where out_valid && out_ready.
REQ-013 Input SHALL be sampled on every rising edge with in_valid high; there is no input backpressure.
REQ-014 NUL bytes (8'h00) SHALL be discarded and never written to the FIFO.
REQ-015 Any other byte in IDLE or STREAM SHALL be pushed to the FIFO.
REQ-016 Pushes SHALL be first-word-fall-through: a byte pushed at edge N SHALL drive ascii_out with out_valid high from edge N onward if the FIFO was empty, giving a latency of 1 cycle.
REQ-017 Byte order SHALL be preserved.
REQ-018 ascii_out SHALL read 8'h00 whenever out_valid is low.
REQ-019 Full FIFO with a pop in the same cycle: the push SHALL succeed.
REQ-020 Full FIFO with no pop: a non-NUL byte SHALL be dropped and overflow SHALL set.
REQ-021 Empty FIFO with a simultaneous push and pop: the pop SHALL only take effect if out_valid was already high.
REQ-022 Pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full and empty SHALL be derived from the MSB compare.
REQ-023 States SHALL be IDLE, STREAM, DRAIN and DONE.
REQ-024 IDLE -> STREAM on the first accepted non-NUL, non-EOT byte.
REQ-025 IDLE or STREAM -> DRAIN on accepting EOT (8'h04); the EOT byte SHALL itself be pushed as the final byte.
REQ-026 In DRAIN, all input SHALL be ignored and SHALL not set overflow.
REQ-027 DRAIN -> DONE on the edge the EOT byte is popped.
REQ-028 DONE SHALL assert eot_done for exactly one cycle, then go to IDLE.
REQ-029 An EOT dropped for overflow SHALL NOT cause a transition.

Reset
REQ-030 On rst: out_valid=0, ascii_out=8'h00, busy=0, eot_done=0, overflow=0, state=IDLE, pointers=0.
REQ-031 FIFO contents SHALL NOT be reset.
REQ-032 Reset asserted mid-message SHALL discard all buffered bytes; no eot_done SHALL follow.
REQ-033 overflow SHALL clear only on rst.

Configuration
REQ-034 Macro ASCII_COMPACTOR_STATS_EN defined: add outputs drop_count[15:0] (NULs discarded) and char_count[15:0] (bytes pushed).
REQ-035 Both counters SHALL reset to 0 and saturate at 16'hFFFF.
REQ-036 Both counters SHALL clear on the DONE cycle after it.
REQ-037 Macro undefined: the ports and counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-038 Shared package ascii_pkg SHALL hold the constants ASCII_NUL=8'h00 and ASCII_EOT=8'h04, plus the state enum compactor_state_t.
REQ-039 Storage and pointers SHALL live in sub-module sync_fifo (parameter DEPTH, width 8).
REQ-040 The state machine and drop logic SHALL live in ascii_compactor.

Verification
REQ-041 "Hll Wrld!" with 8'h00 at the vowel positions, out_ready=1 -> out stream "Hll Wrld!", 9 bytes, order kept, each byte 1 cycle after input.
REQ-042 DEPTH=4, out_ready=0, 6 non-NUL bytes -> first 4 held, overflow=1, then out_ready=1 -> exactly those 4 bytes out.
REQ-043 "AB",8'h04,"CD" with out_ready toggling every cycle -> out "AB",8'h04; "CD" ignored; eot_done pulses once on the edge after 8'h04 pops; then state IDLE, busy=0.
REQ-044 Full FIFO with out_ready=1 and a push in the same cycle -> no overflow, count stays DEPTH.
REQ-045 rst asserted asynchronously with 3 bytes buffered -> out_valid=0 immediately, no eot_done; fresh "X" afterwards -> out "X".
REQ-046 With ASCII_COMPACTOR_STATS_EN, the REQ-041 stimulus -> drop_count=3, char_count=9; the stimulus contains no EOT, so no DONE occurs and the counts hold these values.
